k053260_rom_arb: RTL and testbench

- Shares the single 8-bit sample-ROM read port between the four PCM channel fetch units and the CPU ROM-readback path.
- Arbitrates round-robin among NCH+1 requesters and issues one ROM read at a time.
- Waits the fixed ROM latency, then returns the data byte tagged with the requester index.
- Sits between the channel pitch/address counters and the external ROM bus.

---
 rtl/k053260_rom_arb.sv | 123 ++++++++++++
 tb/tb_k053260_rom_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/k053260_rom_arb.sv
// k053260_rom_arb: round-robin arbiter sharing the 8-bit sample-ROM read port
// between NCH PCM channel fetch units and the CPU readback path (index NCH).
// Ports:
//   CLK, RES           clock, synchronous active-high reset
//   REQ, ADDR_IN       per-channel level requests and addresses (ch i at [i*AW +: AW])
//   CPU_REQ, CPU_ADDR  CPU readback request and address
//   GNT, ACK           one-hot grant / data-valid pulses, bit NCH = CPU
//   CH, DOUT, DVALID   owner index, fetched byte, valid strobe
//   ROM_A, ROM_RD      ROM address and read strobe
//   ROM_D              ROM data, sampled LAT cycles after the ROM_RD cycle
//   BUSY               a fetch is in flight (READ or WAIT)
module k053260_rom_arb #(
  parameter int NCH = 4,
  parameter int AW  = 21,
  parameter int LAT = 2
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [NCH-1:0]   REQ,
  input  logic [NCH*AW-1:0] ADDR_IN,
  input  logic             CPU_REQ,
  input  logic [AW-1:0]    CPU_ADDR,
  output logic [NCH:0]     GNT,
  output logic [NCH:0]     ACK,
  output logic [2:0]       CH,
  output logic [7:0]       DOUT,
  output logic             DVALID,
  output logic [AW-1:0]    ROM_A,
  output logic             ROM_RD,
  input  logic [7:0]       ROM_D,
  output logic             BUSY
);
  localparam int CW = (LAT > 1) ? $clog2(LAT + 1) : 1;
  localparam logic [NCH:0] ONE = {{NCH{1'b0}}, 1'b1};
  // The DONE cycle is IDLE with dv_q set, so arbitration overlaps the data return.
  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;
  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d, own_q, own_d, ch_q, ch_d, win;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      dout_q, dout_d;
  logic            dv_q, dv_d, found;
  logic [NCH:0]    req_m;
  logic [AW-1:0]   addr_tab [NCH+1];
  for (genvar i = 0; i < NCH; i++) begin : g_addr
    assign addr_tab[i] = ADDR_IN[i*AW +: AW];
  end
  assign addr_tab[NCH] = CPU_ADDR;
  assign ACK    = dv_q ? ONE << ch_q : '0;
  assign DVALID = dv_q;
  assign DOUT   = dout_q;
  assign CH     = ch_q;
  assign ROM_A  = addr_q;
  assign ROM_RD = state_q == READ;
  assign BUSY   = state_q != IDLE;
  // Scan from PTR upward with wrap; iterating downward leaves the nearest hit in win.
  // The requester being ACKed this cycle is masked so a held REQ cannot win twice in a row.
  always_comb begin
    req_m = {CPU_REQ, REQ} & ~ACK;
    found = 1'b0;
    win   = '0;
    for (int k = NCH; k >= 0; k--) begin
      if (req_m[(int'(ptr_q) + k) % (NCH + 1)]) begin
        found = 1'b1;
        win   = 3'((int'(ptr_q) + k) % (NCH + 1));
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    GNT     = '0;
    case (state_q)
      IDLE: if (found) begin
        GNT     = ONE << win;
        addr_d  = addr_tab[win];
        own_d   = win;
        ptr_d   = win == 3'(NCH) ? '0 : win + 3'd1;
        state_d = READ;
      end
      READ: begin
        cnt_d   = CW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        dout_d  = ROM_D;
        ch_d    = own_q;
        dv_d    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end
endmodule

// File: tb/tb_k053260_rom_arb.sv
// tb_k053260_rom_arb: scoreboard bench with a transaction-level model of the ROM arbiter.
module tb_k053260_rom_arb;
  localparam int NCH = 4, AW = 21, LAT = 2, N = NCH + 1;
  logic CLK = 0, RES = 1, CPU_REQ = 0, DVALID, ROM_RD, BUSY;
  logic [NCH-1:0] REQ = '0;
  logic [NCH*AW-1:0] ADDR_IN = '0;
  logic [AW-1:0] CPU_ADDR = '0, ROM_A;
  logic [NCH:0] GNT, ACK;
  logic [2:0] CH;
  logic [7:0] DOUT, ROM_D = '0;
  k053260_rom_arb #(.NCH(NCH), .AW(AW), .LAT(LAT)) dut (
    .CLK(CLK), .RES(RES), .REQ(REQ), .ADDR_IN(ADDR_IN), .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR),
    .GNT(GNT), .ACK(ACK), .CH(CH), .DOUT(DOUT), .DVALID(DVALID), .ROM_A(ROM_A),
    .ROM_RD(ROM_RD), .ROM_D(ROM_D), .BUSY(BUSY));
  always #5 CLK = ~CLK;
  typedef struct {int idx; logic [7:0] data; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, ptr_m = 0, free_at = 0, rd_cyc = -100, rom_due = -1;
  int checks = 0, passes = 0;
  logic [AW-1:0] rd_addr = '0, rom_addr = '0;
  logic [7:0] last_dout = '0;
  bit rst_seen = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [7:0] rom(input logic [AW-1:0] a);
    return 8'((a * 37) ^ (a >> 9));
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
  endtask
  // Predictor: whenever the model says the port is free, the winner is the first
  // live requester from the pointer (minus the one being acknowledged right now).
  always @(negedge CLK) begin
    logic [N-1:0] r;
    logic [AW-1:0] a;
    int w;
    if (RES) begin
      q.delete();
      ptr_m = 0; free_at = cyc + 1; rd_cyc = -100; rom_due = -1;
    end else begin
      if (ROM_RD) begin rom_due = cyc + LAT; rom_addr = ROM_A; end
      if (cyc >= free_at) begin
        r = {CPU_REQ, REQ};
        if (q.size() > 0 && q[0].due == cyc) r[q[0].idx] = 1'b0;
        w = -1;
        for (int k = N - 1; k >= 0; k--) if (r[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        chk("gnt", 32'(GNT), w < 0 ? 32'd0 : 32'd1 << w);
        if (w >= 0) begin
          a = (w == NCH) ? CPU_ADDR : ADDR_IN[w*AW +: AW];
          q.push_back('{w, rom(a), cyc + 2 + LAT});
          rd_cyc = cyc + 1; rd_addr = a; free_at = cyc + 2 + LAT; ptr_m = (w + 1) % N;
        end
      end else chk("gnt_busy", 32'(GNT), 0);
    end
    ROM_D = (cyc == rom_due) ? rom(rom_addr) : 8'($urandom);
  end
  // Monitor: compares bus activity and pops the scoreboard whenever DVALID shows.
  always @(negedge CLK) begin
    exp_t e;
    bit bexp;
    #1;
    if (RES) begin
      rst_seen = 1; last_dout = '0;
    end else begin
      if (rst_seen) begin
        rst_seen = 0;
        chk("rst_dvalid", 32'(DVALID), 0); chk("rst_ack", 32'(ACK), 0);
        chk("rst_rom_a", 32'(ROM_A), 0); chk("rst_ch", 32'(CH), 0);
        chk("rst_busy", 32'(BUSY), 0); chk("rst_rom_rd", 32'(ROM_RD), 0);
      end
      bexp = cyc >= rd_cyc && cyc <= rd_cyc + LAT;
      chk("rom_rd", 32'(ROM_RD), 32'(cyc == rd_cyc));
      chk("busy", 32'(BUSY), 32'(bexp));
      if (bexp) chk("rom_a", 32'(ROM_A), 32'(rd_addr));
      if (DVALID) begin
        if (q.size() == 0) chk("dvalid_unexpected", 32'(DVALID), 0);
        else begin
          e = q.pop_front();
          chk("dv_cycle", cyc, e.due);
          chk("ch", 32'(CH), e.idx);
          chk("dout", 32'(DOUT), 32'(e.data));
          chk("ack", 32'(ACK), 32'd1 << e.idx);
          last_dout = e.data;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) chk("dvalid_missing", 32'(DVALID), 1);
        chk("ack_idle", 32'(ACK), 0);
        chk("dout_hold", 32'(DOUT), 32'(last_dout));
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge CLK); #2; end
  endtask
  initial begin
    int n;
    step(3);
    RES = 0;
    ADDR_IN[0 +: AW] = 21'h12345; REQ = 4'b0001;
    step(); REQ = '0; step(6);
    CPU_ADDR = AW'($urandom);
    for (int i = 0; i < NCH; i++) ADDR_IN[i*AW +: AW] = AW'($urandom);
    REQ = 4'hF; CPU_REQ = 1;
    step(25); REQ = '0; CPU_REQ = 0; step(6);
    ADDR_IN[1*AW +: AW] = 21'h00100; REQ = 4'b0010;
    step(); ADDR_IN[1*AW +: AW] = 21'h1FFFF; REQ = '0; step(6);
    CPU_ADDR = 21'h0ABCD; CPU_REQ = 1;
    step(); CPU_REQ = 0; step();
    RES = 1; step(); RES = 0;
    REQ = 4'b1001; CPU_REQ = 1; step(12); REQ = '0; CPU_REQ = 0; step(6);
    CPU_ADDR = '1; CPU_REQ = 1;
    step(); CPU_REQ = 0; step(6);
    repeat (3000) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 5) == 0) REQ[i] = ~REQ[i];
        if ($urandom_range(0, 3) == 0) ADDR_IN[i*AW +: AW] = AW'($urandom);
      end
      if ($urandom_range(0, 5) == 0) CPU_REQ = ~CPU_REQ;
      if ($urandom_range(0, 3) == 0) CPU_ADDR = AW'($urandom);
      RES = $urandom_range(0, 99) == 0;
      step();
    end
    RES = 0; REQ = '0; CPU_REQ = 0;
    n = 0;
    while (q.size() > 0 && n < 20) begin step(); n++; end
    chk("drain", q.size(), 0);
    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
